// File: rtl/pool_fc_sequencer.sv
// Max-pool / fully-connected stage controller: steps the pooled-map position
// while windows stream in, then issues the FC multiply-accumulate, drains the MAC.
module pool_fc_sequencer #(
  parameter int POOL_X   = 12,
  parameter int POOL_Y   = 12,
  parameter int CHANNELS = 8,
  parameter int MAC_LAT  = 2,
  parameter int NFEAT    = CHANNELS * POOL_X * POOL_Y,
  parameter int AW       = $clog2(NFEAT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          win_valid,
  output logic          win_ready,
  output logic [4:0]    count_x,
  output logic [4:0]    count_y,
  output logic          pool_wr_en,
  input  logic          fc_hold,
  output logic [AW-1:0] feat_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          busy,
  output logic          fc_done
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [4:0]    X_LAST = 5'(POOL_X - 1);
  localparam logic [4:0]    Y_LAST = 5'(POOL_Y - 1);
  localparam logic [AW-1:0] F_LAST = AW'(NFEAT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POOL  = 3'd1,
    S_FC    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    count_x_q, count_x_d;
  logic [4:0]    count_y_q, count_y_d;
  logic [AW-1:0] feat_addr_q, feat_addr_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          mac_clr_q, mac_clr_d;
  logic          busy_q, busy_d;
  logic          fc_done_q, fc_done_d;

  // Handshake and MAC issue decode straight from state so they track inputs in-cycle.
  assign win_ready  = (state_q == S_POOL);
  assign pool_wr_en = win_valid & win_ready;
  assign mac_en     = (state_q == S_FC) & ~fc_hold;

  assign count_x   = count_x_q;
  assign count_y   = count_y_q;
  assign feat_addr = feat_addr_q;
  assign mac_clr   = mac_clr_q;
  assign busy      = busy_q;
  assign fc_done   = fc_done_q;

  // Next-state and next-register computation.
  always_comb begin
    state_d     = state_q;
    count_x_d   = count_x_q;
    count_y_d   = count_y_q;
    feat_addr_d = feat_addr_q;
    drain_cnt_d = drain_cnt_q;
    mac_clr_d   = 1'b0;
    busy_d      = busy_q;
    fc_done_d   = fc_done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_POOL;
          count_x_d   = 5'd0;
          count_y_d   = 5'd0;
          feat_addr_d = '0;
          drain_cnt_d = '0;
          mac_clr_d   = 1'b1;
          busy_d      = 1'b1;
          fc_done_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_POOL: begin
        if (pool_wr_en) begin
          if (count_y_q == Y_LAST) begin
            count_y_d = 5'd0;
            if (count_x_q == X_LAST) begin
              count_x_d   = 5'd0;
              feat_addr_d = '0;
              state_d     = S_FC;
            end else begin
              count_x_d = count_x_q + 5'd1;
            end
          end else begin
            count_y_d = count_y_q + 5'd1;
          end
        end else begin
          count_y_d = count_y_q;
        end
      end
      S_FC: begin
        // The last issued feature address is kept; the drain counter restarts here.
        if (mac_en) begin
          if (feat_addr_q == F_LAST) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end else begin
            feat_addr_d = feat_addr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end else begin
          feat_addr_d = feat_addr_q;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == D_LAST) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          fc_done_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        fc_done_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_x_q   <= 5'd0;
      count_y_q   <= 5'd0;
      feat_addr_q <= '0;
      drain_cnt_q <= '0;
      mac_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      fc_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_x_q   <= count_x_d;
      count_y_q   <= count_y_d;
      feat_addr_q <= feat_addr_d;
      drain_cnt_q <= drain_cnt_d;
      mac_clr_q   <= mac_clr_d;
      busy_q      <= busy_d;
      fc_done_q   <= fc_done_d;
    end
  end

endmodule

// File: tb/tb_pool_fc_sequencer.sv
// Bench for pool_fc_sequencer: count-based behavioural model, per-cycle compare,
// plus literal latency/count expectations for each image.
module tb_pool_fc_sequencer;
  localparam int POOL_X   = 12;
  localparam int POOL_Y   = 12;
  localparam int CHANNELS = 8;
  localparam int MAC_LAT  = 2;
  localparam int NPOS     = POOL_X * POOL_Y;
  localparam int NFEAT    = CHANNELS * NPOS;
  localparam int AW       = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          win_valid = 1'b0;
  logic          fc_hold = 1'b0;
  logic          win_ready, pool_wr_en, mac_clr, mac_en, busy, fc_done;
  logic [4:0]    count_x, count_y;
  logic [AW-1:0] feat_addr;

  always #5 clk = ~clk;

  pool_fc_sequencer #(.POOL_X(POOL_X), .POOL_Y(POOL_Y), .CHANNELS(CHANNELS),
                      .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_valid(win_valid),
    .win_ready(win_ready), .count_x(count_x), .count_y(count_y),
    .pool_wr_en(pool_wr_en), .fc_hold(fc_hold), .feat_addr(feat_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .fc_done(fc_done)
  );

  // Behavioural model: progress is tracked as handshakes, MACs and drain cycles done.
  int   m_hs = 0, m_nmac = 0, m_drain = 0;
  logic m_active = 1'b0, m_done = 1'b0, m_clr = 1'b0;
  logic m_in_pool, m_in_fc;
  assign m_in_pool = m_active && (m_hs < NPOS);
  assign m_in_fc   = m_active && (m_hs == NPOS) && (m_nmac < NFEAT);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hs <= 0; m_nmac <= 0; m_drain <= 0;
      m_active <= 1'b0; m_done <= 1'b0; m_clr <= 1'b0;
    end else if (!m_active) begin
      m_clr <= start;
      if (start) begin
        m_active <= 1'b1; m_done <= 1'b0;
        m_hs <= 0; m_nmac <= 0; m_drain <= 0;
      end
    end else begin
      m_clr <= 1'b0;
      if (m_in_pool) begin
        if (win_valid) m_hs <= m_hs + 1;
      end else if (m_in_fc) begin
        if (!fc_hold) m_nmac <= m_nmac + 1;
      end else begin
        m_drain <= m_drain + 1;
        if (m_drain == MAC_LAT - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end
  end

  // Stimulus controls owned by the sequencing initial block.
  int   mode = 0;
  int   cyc = 0;
  int   start_seq = 0;
  int   exp_done_cyc = 0;
  int   timeouts = 0;
  logic finish_req = 1'b0;

  // Driver state owned by the driver process.
  int   start_ack = 0;
  int   holds = 0;
  logic p1 = 1'b0, p2 = 1'b0;

  always @(posedge clk) begin
    #2;
    start = 1'b0;
    if (start_seq != start_ack) begin
      start = 1'b1; start_ack = start_seq;
      holds = 0; p1 = 1'b0; p2 = 1'b0;
    end
    case (mode)
      0: begin win_valid = 1'b1; fc_hold = 1'b0; end
      1: begin win_valid = (cyc % 2 == 0); fc_hold = 1'b0; end
      3: begin
        win_valid = 1'b1; fc_hold = 1'b0;
        if (m_in_fc && m_nmac == 600 && holds < 5) begin fc_hold = 1'b1; holds++; end
      end
      4: begin
        win_valid = 1'b1; fc_hold = 1'b0;
        if (m_in_pool && m_hs == 3 * POOL_Y + 7 && !p1) begin start = 1'b1; p1 = 1'b1; end
        if (m_in_fc && m_nmac == 500 && !p2) begin start = 1'b1; p2 = 1'b1; end
      end
      default: begin
        win_valid = 1'($urandom_range(0, 1));
        fc_hold   = ($urandom_range(0, 3) == 0);
      end
    endcase
  end

  // Compare process: owns every comparison and the summary.
  int n_checks = 0, n_fail = 0;
  int n_pool = 0, n_mac = 0, images_done = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int e_cx, e_cy, e_fa;
    forever begin
      @(negedge clk or negedge rst_n or posedge finish_req);
      #1;
      if (finish_req) begin
        chk("no_timeouts", timeouts, 0);
        chk("images_done", images_done, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
      e_cx = (m_hs % NPOS) / POOL_Y;
      e_cy = m_hs % POOL_Y;
      e_fa = (m_nmac == NFEAT) ? NFEAT - 1 : m_nmac;
      chk("count_x", int'(count_x), e_cx);
      chk("count_y", int'(count_y), e_cy);
      chk("feat_addr", int'(feat_addr), e_fa);
      chk("win_ready", int'(win_ready), int'(m_in_pool));
      chk("pool_wr_en", int'(pool_wr_en), int'(m_in_pool & win_valid));
      chk("mac_en", int'(mac_en), int'(m_in_fc & ~fc_hold));
      chk("mac_clr", int'(mac_clr), int'(m_clr));
      chk("busy", int'(busy), int'(m_active));
      chk("fc_done", int'(fc_done), int'(m_done));
      if (!rst_n)
        chk("reset_outputs_zero", int'({win_ready, count_x, count_y, pool_wr_en, feat_addr,
                                       mac_clr, mac_en, busy, fc_done}), 0);
      if (rst_n && cyc == 1)
        chk("cycle1_clr_busy_done", int'({mac_clr, busy, fc_done}), 6);
      if (mac_clr) begin n_pool = 0; n_mac = 0; end
      if (pool_wr_en) begin
        chk("pool_order", int'(count_x) * POOL_Y + int'(count_y), n_pool);
        n_pool++;
      end
      if (mac_en) begin
        chk("feat_sequence", int'(feat_addr), n_mac);
        n_mac++;
      end
      if (fc_done && !prev_done && rst_n) begin
        images_done++;
        chk("pool_pulses", n_pool, NPOS);
        chk("mac_pulses", n_mac, NFEAT);
        if (exp_done_cyc != 0) chk("done_latency", cyc, exp_done_cyc);
      end
      prev_done = fc_done;
    end
  end

  task automatic begin_image(input int m);
    mode = m;
    start_seq++;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (start) break;
    end
    cyc = 1;
  endtask

  task automatic run_image(input int m, input int exp);
    exp_done_cyc = exp;
    begin_image(m);
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (fc_done) break;
      if (k == 5999) begin
        timeouts++;
        $display("FAIL image_timeout: fc_done never rose (mode %0d)", m);
      end
      @(posedge clk);
      cyc++;
    end
    mode = 2;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #3 rst_n = 1'b1;
    mode = 2;
    repeat (4) @(posedge clk);
    run_image(0, 1299);               // baseline minimum latency
    run_image(1, 1299 + NPOS);        // win_valid every other cycle, restart from DONE
    run_image(3, 1299 + 5);           // 5-cycle fc_hold at feature 600
    run_image(4, 1299);               // stray starts in POOL and FC are dropped
    run_image(2, 0);                  // random valid/hold
    // Asynchronous reset in the middle of FC, then a clean image.
    exp_done_cyc = 0;
    begin_image(0);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (m_in_fc && m_nmac == 300) break;
      if (k == 2999) begin
        timeouts++;
        $display("FAIL reach_feat300: model never reached feature 300");
      end
      @(posedge clk);
      cyc++;
    end
    #3 rst_n = 1'b0;
    cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_image(0, 1299);
    finish_req = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pool_fc_sequencer.md
Name: pool_fc_sequencer

Overview:
Controller for the max-pool and fully-connected stage that follows ReLU. It accepts 2x2 pooling windows from the ReLU stage through a valid/ready handshake, and it generates the (count_x, count_y) position and the write strobe for the pooled-feature buffer. After all 12x12 positions are stored, it sequences the FC multiply-accumulate over all pooled features, one per cycle. It then drains the MAC pipeline and raises fc_done.

Parameters:
POOL_X, 12, pooled map rows (count_x range 0..POOL_X-1)
POOL_Y, 12, pooled map columns (count_y range 0..POOL_Y-1)
CHANNELS, 8, feature maps pooled in parallel per window
MAC_LAT, 2, cycles from the last mac_en to a valid final accumulator value
NFEAT, CHANNELS*POOL_X*POOL_Y (1152), FC input length
AW, 11, feature address width, equal to ceil(log2(NFEAT))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins an image; honoured only in IDLE or DONE
win_valid  in  1  upstream presents 8 pooling windows for the current position
win_ready  out  1  sequencer accepts a window (high only in POOL)
count_x  out  5  row of the current pooled position
count_y  out  5  column of the current pooled position
pool_wr_en  out  1  write strobe to the pooled buffer; equals win_valid & win_ready
fc_hold  in  1  weight/feature memory not ready; freezes FC issue
feat_addr  out  AW  feature/weight index for the FC MAC
mac_clr  out  1  one-cycle clear of the prob accumulators
mac_en  out  1  accumulate feature feat_addr this cycle
busy  out  1  high in POOL, FC and DRAIN
fc_done  out  1  FC results valid; held high until the next start

Behaviour:
- FSM states: IDLE, POOL, FC, DRAIN, DONE. All outputs are registered except pool_wr_en, win_ready and mac_en, which decode from the state.
- Reset (asynchronous, rst_n=0) forces the following on the same edge, regardless of state: state=IDLE, count_x=0, count_y=0, feat_addr=0, drain counter=0, mac_clr=0, fc_done=0, busy=0.
- IDLE/DONE: on start=1, the next state is POOL and counters are zeroed. mac_clr=1 for exactly the first POOL cycle. fc_done clears on that same edge.
- POOL:
  - win_ready=1.
  - On a handshake (win_valid=1), count_y increments.
  - When count_y=POOL_Y-1, count_y wraps to 0 and count_x increments.
  - A handshake at (POOL_X-1, POOL_Y-1) moves to FC. count_x and count_y return to 0, and feat_addr=0.
  - With win_valid=0 the counters hold.
  - start is ignored.
- FC:
  - mac_en = ~fc_hold.
  - When mac_en=1, feat_addr increments. When fc_hold=1, feat_addr holds and mac_en=0.
  - Issuing mac_en at feat_addr=NFEAT-1 moves to DRAIN. feat_addr stays at NFEAT-1.
- DRAIN: counts MAC_LAT cycles with mac_en=0 and fc_hold ignored, then moves to DONE with fc_done=1.
- DONE: busy=0, fc_done=1. Counters hold. A new start restarts as described for IDLE.
- Inputs outside their states:
  - win_valid outside POOL produces no pool_wr_en and no counter change.
  - fc_hold outside FC has no effect.
  - start in POOL/FC/DRAIN is dropped, not queued.
- Totals: exactly POOL_X*POOL_Y pool_wr_en pulses and exactly NFEAT mac_en pulses per image. feat_addr visits 0..NFEAT-1 in order with no repeats or skips.
- Minimum latency with win_valid tied high and fc_hold low:
  - start at edge 0.
  - POOL spans cycles 1..144.
  - FC spans cycles 145..1296.
  - DRAIN spans cycles 1297..1298.
  - fc_done is first high in cycle 1299.

Test Plan:
- Reset then start with win_valid=1 and fc_hold=0 -> 144 pool_wr_en pulses in (x,y) order (0,0),(0,1)..(0,11),(1,0)..(11,11); then 1152 mac_en pulses with feat_addr 0..1151; fc_done first high in cycle 1299 after start; mac_clr high only in cycle 1.
- Toggle win_valid every other cycle in POOL -> 144 handshakes over 288 cycles; count_y holds during gaps; transition to FC follows the (11,11) handshake.
- Assert fc_hold for 5 cycles at feat_addr=600 -> feat_addr stays 600 and mac_en=0 for those 5 cycles; total mac_en still 1152; fc_done 5 cycles later than baseline.
- Pulse start during POOL at (3,7) and again in FC -> ignored: no counter reset, no mac_clr.
- Drop rst_n mid-FC at feat_addr=300 -> all outputs zero asynchronously; state IDLE; after release, a new start runs a full image correctly.
- Issue start in DONE -> fc_done falls on the accepting edge; mac_clr pulses; second image completes with identical counts.
